// File: rtl/pong_pkg.sv
// Shared direction encodings, controller states and field centre for the pong datapath.
package pong_pkg;

  localparam logic [1:0] DIR_POS  = 2'b01;
  localparam logic [1:0] DIR_NEG  = 2'b11;
  localparam logic [1:0] DIR_ZERO = 2'b00;

  typedef enum logic [1:0] {SERVE, PLAY, SCORED, OVER} state_e;

  // Where the position stage parks the ball while en is low.
  localparam int CX = 3;
  localparam int CY = 4;

endpackage

// File: rtl/ball_ctrl_score_cnt.sv
// Saturating 4-bit score counter; clear wins over increment, value is registered.
module score_cnt #(
  parameter int MAX = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       clr_i,
  output logic [3:0] cnt_o,
  output logic       at_max_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && !at_max_o) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  assign cnt_o    = cnt_q;
  assign at_max_o = (cnt_q == 4'(MAX));

endmodule

// File: rtl/ball_ctrl.sv
// Ball direction / game-flow controller feeding the position stage; all outputs registered, paced by tick.
// BALL_CTRL_ANGLE_EN: paddle contact row steers y_dir and serves go out flat.
module ball_ctrl
  import pong_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int BIT_OF_WIDTH = 3,
  parameter int PAD_LEN      = 3,
  parameter int SCORE_HOLD   = 4,
  parameter int MAX_SCORE    = 9
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic                    serve,
  input  logic [BIT_OF_WIDTH-1:0] x_pos,
  input  logic [BIT_OF_WIDTH-1:0] y_pos,
  input  logic [BIT_OF_WIDTH-1:0] pad_l_y,
  input  logic [BIT_OF_WIDTH-1:0] pad_r_y,
  output logic [3:0]              vector,
  output logic                    en,
  output logic [3:0]              score_l,
  output logic [3:0]              score_r,
  output logic                    point,
  output logic                    game_over
);

  localparam int BW = BIT_OF_WIDTH;
  localparam int HW = $clog2(SCORE_HOLD + 1);
  localparam logic [BW-1:0] POS_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] POS_PRE  = BW'(WIDTH - 2);
  localparam logic [BW-1:0] POS_ONE  = BW'(1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(SCORE_HOLD - 1);
  localparam logic [3:0]    SCORE_PRE = 4'(MAX_SCORE - 1);
`ifdef BALL_CTRL_ANGLE_EN
  localparam logic [1:0] SERVE_Y = DIR_ZERO;
`else
  localparam logic [1:0] SERVE_Y = DIR_POS;
`endif

  state_e        state_q;
  logic [3:0]    vector_q;
  logic          en_q, point_q, game_over_q, serve_q;
  logic [1:0]    serve_dir_q;
  logic [HW-1:0] hold_q;
  logic [1:0]    x_dir, y_dir, x_dir_d, y_dir_d;
  logic          serve_rise, hit_l, hit_r, miss_l, miss_r, last_pt;
  logic          inc_l, inc_r, clr_sc, at_max_l, at_max_r;

  // Extend by one bit so a paddle hanging past the bottom row does not wrap.
  function automatic logic on_pad(input logic [BW-1:0] y, input logic [BW-1:0] top);
    logic [BW:0] y_e, top_e, bot_e;
    y_e   = {1'b0, y};
    top_e = {1'b0, top};
    bot_e = top_e + (BW+1)'(PAD_LEN - 1);
    return (y_e >= top_e) && (y_e <= bot_e);
  endfunction

`ifdef BALL_CTRL_ANGLE_EN
  function automatic logic [1:0] angle_y(input logic [BW-1:0] y, input logic [BW-1:0] top,
                                         input logic [1:0] cur);
    logic [BW:0] bot_e;
    bot_e = {1'b0, top} + (BW+1)'(PAD_LEN - 1);
    if (y == top)                return DIR_NEG;
    else if ({1'b0, y} == bot_e) return DIR_POS;
    else if (cur == DIR_ZERO)    return DIR_POS;
    else                         return cur;
  endfunction
`endif

  assign x_dir      = vector_q[3:2];
  assign y_dir      = vector_q[1:0];
  assign serve_rise = serve && !serve_q;
  assign hit_l      = (x_pos == POS_ONE) && (x_dir == DIR_NEG) && on_pad(y_pos, pad_l_y);
  assign hit_r      = (x_pos == POS_PRE) && (x_dir == DIR_POS) && on_pad(y_pos, pad_r_y);
  assign miss_l     = (x_pos == '0);
  assign miss_r     = (x_pos == POS_LAST);
  assign last_pt    = miss_l ? (score_r == SCORE_PRE) : (score_l == SCORE_PRE);
  assign inc_r      = (state_q == PLAY) && tick && miss_l && !at_max_l && !at_max_r;
  assign inc_l      = (state_q == PLAY) && tick && miss_r && !at_max_l && !at_max_r;
  assign clr_sc     = (state_q == OVER) && serve_rise;

  always_comb begin
    x_dir_d = x_dir;
    y_dir_d = y_dir;
    if ((y_pos == '0) && (y_dir == DIR_NEG))            y_dir_d = DIR_POS;
    else if ((y_pos == POS_LAST) && (y_dir == DIR_POS)) y_dir_d = DIR_NEG;
    if (hit_l) begin
      x_dir_d = DIR_POS;
`ifdef BALL_CTRL_ANGLE_EN
      y_dir_d = angle_y(y_pos, pad_l_y, y_dir_d);
`endif
    end
    if (hit_r) begin
      x_dir_d = DIR_NEG;
`ifdef BALL_CTRL_ANGLE_EN
      y_dir_d = angle_y(y_pos, pad_r_y, y_dir_d);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SERVE;
      vector_q    <= '0;
      en_q        <= 1'b0;
      point_q     <= 1'b0;
      game_over_q <= 1'b0;
      serve_q     <= 1'b0;
      serve_dir_q <= DIR_POS;
      hold_q      <= '0;
    end else begin
      serve_q <= serve;
      point_q <= 1'b0;
      case (state_q)
        SERVE: if (serve_rise) begin
          state_q  <= PLAY;
          en_q     <= 1'b1;
          vector_q <= {serve_dir_q, SERVE_Y};
        end
        PLAY: if (tick) begin
          if (miss_l || miss_r) begin
            point_q     <= 1'b1;
            en_q        <= 1'b0;
            vector_q    <= '0;
            hold_q      <= '0;
            serve_dir_q <= miss_l ? DIR_NEG : DIR_POS;
            if (last_pt) begin
              state_q     <= OVER;
              game_over_q <= 1'b1;
            end else begin
              state_q <= SCORED;
            end
          end else begin
            vector_q <= {x_dir_d, y_dir_d};
          end
        end
        SCORED: if (tick) begin
          if (hold_q == HOLD_LAST) state_q <= SERVE;
          else                     hold_q  <= hold_q + 1'b1;
        end
        OVER: if (serve_rise) begin
          state_q     <= SERVE;
          game_over_q <= 1'b0;
          serve_dir_q <= DIR_POS;
        end
        default: state_q <= SERVE;
      endcase
    end
  end

  score_cnt #(.MAX(MAX_SCORE)) u_score_l (
    .clk(clk), .rst_n(rst_n), .inc_i(inc_l), .clr_i(clr_sc), .cnt_o(score_l), .at_max_o(at_max_l)
  );

  score_cnt #(.MAX(MAX_SCORE)) u_score_r (
    .clk(clk), .rst_n(rst_n), .inc_i(inc_r), .clr_i(clr_sc), .cnt_o(score_r), .at_max_o(at_max_r)
  );

  assign vector    = vector_q;
  assign en        = en_q;
  assign point     = point_q;
  assign game_over = game_over_q;

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl: serve, paddle and wall bounces, misses, hold, game over and restart.
module tb_ball_ctrl;

  logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b0, serve = 1'b0;
  logic [2:0] x_pos = '0, y_pos = '0, pad_l_y = '0, pad_r_y = '0;
  logic [3:0] vector, score_l, score_r;
  logic       en, point, game_over;

  int applied = 0;
  int miscompares = 0;
  logic [14:0] exp_q[$];
  string       tag_q[$];

`ifdef BALL_CTRL_ANGLE_EN
  localparam logic [1:0] SY = 2'b00;
  localparam logic [3:0] CORNER = 4'b1101;
`else
  localparam logic [1:0] SY = 2'b01;
  localparam logic [3:0] CORNER = 4'b1111;
`endif

  ball_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .serve(serve),
    .x_pos(x_pos), .y_pos(y_pos), .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
    .vector(vector), .en(en), .score_l(score_l), .score_r(score_r),
    .point(point), .game_over(game_over)
  );

  always #5 clk = ~clk;

  // Expected outputs are queued with the stimulus, then checked once the edge has been taken.
  task automatic step(input string tag, input logic [3:0] v, input logic e,
                      input logic [3:0] sl, input logic [3:0] sr, input logic p, input logic g);
    logic [14:0] obs, want;
    string       t;
    exp_q.push_back({v, e, sl, sr, p, g});
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    obs  = {vector, en, score_l, score_r, point, game_over};
    want = exp_q.pop_front();
    t    = tag_q.pop_front();
    applied++;
    assert (obs === want) else begin
      miscompares++;
      $error("FAIL %s: observed vec=%b en=%b sl=%0d sr=%0d pt=%b go=%b expected vec=%b en=%b sl=%0d sr=%0d pt=%b go=%b",
             t, obs[14:11], obs[10], obs[9:6], obs[5:2], obs[1], obs[0],
             want[14:11], want[10], want[9:6], want[5:2], want[1], want[0]);
    end
  endtask

  initial begin
    step("reset", 4'b0000, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step("idle", 4'b0000, 0, 0, 0, 0, 0);
    serve = 1'b1;
    step("serve", {2'b01, SY}, 1, 0, 0, 0, 0);
    step("serve_held", {2'b01, SY}, 1, 0, 0, 0, 0);
    serve = 1'b0; tick = 1'b1; x_pos = 3'd6; y_pos = 3'd3; pad_r_y = 3'd2;
    step("rpad_hit", 4'b1101, 1, 0, 0, 0, 0);
    x_pos = 3'd1; y_pos = 3'd5; pad_l_y = 3'd4;
    step("lpad_hit", 4'b0101, 1, 0, 0, 0, 0);
    tick = 1'b0; x_pos = 3'd0; y_pos = 3'd0;
    step("no_tick", 4'b0101, 1, 0, 0, 0, 0);
    tick = 1'b1; x_pos = 3'd3; y_pos = 3'd7;
    step("wall_bottom", 4'b0111, 1, 0, 0, 0, 0);
    x_pos = 3'd0; y_pos = 3'd0; pad_l_y = 3'd4;
    step("miss_left", 4'b0000, 0, 0, 1, 1, 0);
    tick = 1'b0;
    step("point_end", 4'b0000, 0, 0, 1, 0, 0);
    serve = 1'b1;
    step("scored_serve_ign", 4'b0000, 0, 0, 1, 0, 0);
    serve = 1'b0; tick = 1'b1;
    repeat (3) step("hold", 4'b0000, 0, 0, 1, 0, 0);
    tick = 1'b0; serve = 1'b1;
    step("early_serve_ign", 4'b0000, 0, 0, 1, 0, 0);
    serve = 1'b0; tick = 1'b1;
    step("hold_last", 4'b0000, 0, 0, 1, 0, 0);
    tick = 1'b0; serve = 1'b1;
    step("reserve_left", {2'b11, SY}, 1, 0, 1, 0, 0);
    serve = 1'b0; tick = 1'b1; x_pos = 3'd1; y_pos = 3'd3; pad_l_y = 3'd2;
    step("lpad_mid", 4'b0101, 1, 0, 1, 0, 0);
    x_pos = 3'd6; y_pos = 3'd7; pad_r_y = 3'd5;
    step("corner", CORNER, 1, 0, 1, 0, 0);
    rst_n = 1'b0; tick = 1'b0;
    step("mid_reset", 4'b0000, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      serve = 1'b1; tick = 1'b0;
      step("rally_start", {2'b01, SY}, 1, 4'(i), 0, 0, 0);
      serve = 1'b0; tick = 1'b1; x_pos = 3'd7; y_pos = 3'd3;
      step("miss_right", 4'b0000, 0, 4'(i + 1), 0, 1, 0);
      repeat (4) step("hold_r", 4'b0000, 0, 4'(i + 1), 0, 0, 0);
    end
    serve = 1'b1; tick = 1'b0;
    step("final_start", {2'b01, SY}, 1, 8, 0, 0, 0);
    tick = 1'b1; x_pos = 3'd7;
    step("game_over", 4'b0000, 0, 9, 0, 1, 1);
    tick = 1'b0;
    step("over_held", 4'b0000, 0, 9, 0, 0, 1);
    tick = 1'b1;
    step("over_frozen", 4'b0000, 0, 9, 0, 0, 1);
    tick = 1'b0; serve = 1'b0;
    step("over_release", 4'b0000, 0, 9, 0, 0, 1);
    serve = 1'b1;
    step("restart", 4'b0000, 0, 0, 0, 0, 0);
    serve = 1'b0;
    step("restart_idle", 4'b0000, 0, 0, 0, 0, 0);
    serve = 1'b1;
    step("new_rally", {2'b01, SY}, 1, 0, 0, 0, 0);
    serve = 1'b0;
`ifdef BALL_CTRL_ANGLE_EN
    tick = 1'b1; x_pos = 3'd6; y_pos = 3'd3; pad_r_y = 3'd2;
    step("angle_mid", 4'b1101, 1, 0, 0, 0, 0);
    x_pos = 3'd1; y_pos = 3'd2; pad_l_y = 3'd2;
    step("angle_top", 4'b0111, 1, 0, 0, 0, 0);
    tick = 1'b0;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
